// File: rtl/hilo_mult_unit.sv
// HI/LO multiply/accumulate unit: radix-2 shift-add multiplier with mult, multu, madd, msub, mul, mthi and mtlo.
// Busy/Done are flopped from the next-state decode, so they are glitch-free for the hazard unit.
module hilo_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_ctl,
  input  logic             hi_lo_write,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mul_result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [4:0] OP_MULT  = 5'b00101;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_MADD  = 5'b01100;
  localparam logic [4:0] OP_MSUB  = 5'b01101;
  localparam logic [4:0] OP_MUL   = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10011;

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t          state_q, state_d;
  logic [4:0]      op_q;
  logic            sign_q;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]   prod_q;
  logic [CW-1:0]   cnt_q;

  logic             accept;
  logic             acc_mthi, acc_mtlo, acc_mul;
  logic             signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    res, hilo, acc_sum, acc_dif;

  // Accept decode: HI/LO-writing ops need the qualifier, mul does not.
  always_comb begin
    accept    = start && (state_q == IDLE);
    acc_mthi  = accept && hi_lo_write && (alu_ctl == OP_MTHI);
    acc_mtlo  = accept && hi_lo_write && (alu_ctl == OP_MTLO);
    acc_mul   = accept && ((alu_ctl == OP_MUL) ||
                (hi_lo_write && ((alu_ctl == OP_MULT) || (alu_ctl == OP_MULTU) ||
                                 (alu_ctl == OP_MADD) || (alu_ctl == OP_MSUB))));
    signed_op = (alu_ctl != OP_MULTU);
    mag_a     = (signed_op && a[WIDTH-1]) ? WIDTH'(0) - a : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? WIDTH'(0) - b : b;
    res       = sign_q ? PW'(0) - prod_q : prod_q;
    hilo      = {hi, lo};
    acc_sum   = hilo + res;
    acc_dif   = hilo - res;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_mul) state_d = MUL;
      MUL:     if (cnt_q == CW'(WIDTH - 1)) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == WB);
    end
  end

  // Operand capture, shift-add iterations and architectural writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= 5'b0;
      sign_q     <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      hi         <= '0;
      lo         <= '0;
      mul_result <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_mthi) hi <= a;
          if (acc_mtlo) lo <= a;
          if (acc_mul) begin
            op_q     <= alu_ctl;
            sign_q   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand_q  <= PW'(mag_a);
            mplier_q <= mag_b;
            prod_q   <= '0;
            cnt_q    <= '0;
          end
        end
        MUL: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        WB: begin
          case (op_q)
            OP_MULT, OP_MULTU: {hi, lo} <= res;
            OP_MADD:           {hi, lo} <= acc_sum;
            OP_MSUB:           {hi, lo} <= acc_dif;
            OP_MUL:            mul_result <= res[WIDTH-1:0];
            default:           ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit: reset, signed/unsigned multiply, accumulate, mul and ignore cases.
module tb_hilo_mult_unit;

  localparam int unsigned WIDTH = 32;

  localparam logic [4:0] OP_MULT  = 5'b00101;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_MADD  = 5'b01100;
  localparam logic [4:0] OP_MSUB  = 5'b01101;
  localparam logic [4:0] OP_MUL   = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10011;
  localparam logic [4:0] OP_BAD   = 5'b00010;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [4:0]       alu_ctl;
  logic             hi_lo_write;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] hi, lo, mul_result;
  logic             busy, done;

  int tests = 0;
  int fails = 0;
  int busy_n, done_n, done_at;

  hilo_mult_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctl(alu_ctl), .hi_lo_write(hi_lo_write),
    .a(a), .b(b), .hi(hi), .lo(lo), .mul_result(mul_result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single accept edge; returns 1 ns into the following cycle.
  task automatic issue(input logic [4:0] code, input logic hlw,
                       input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    start = 1'b1; alu_ctl = code; hi_lo_write = hlw; a = av; b = bv;
    tick();
    start = 1'b0;
  endtask

  // Profile Busy/Done after an accept; optionally pokes a mult start in cycles poke_a/poke_b.
  task automatic watch(input int poke_a, input int poke_b,
                       output int bn, output int dn, output int dat);
    bn = 0; dn = 0; dat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (done) begin dn++; dat = i; end
      if (!busy) break;
      bn++;
      if (i == poke_a || i == poke_b) begin
        start = 1'b1; alu_ctl = OP_MULT; hi_lo_write = 1'b1; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; alu_ctl = 5'b0; hi_lo_write = 1'b0; a = '0; b = '0;
    tick();
    chk("reset hi", 64'(hi), 64'h0);
    chk("reset lo", 64'(lo), 64'h0);
    chk("reset mul_result", 64'(mul_result), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    rst = 1'b1;
    tick();

    // Preset HI/LO, then mul must leave them alone.
    issue(OP_MTHI, 1'b1, 32'h12345678, 32'h0);
    chk("mthi preset", 64'(hi), 64'h12345678);
    issue(OP_MTLO, 1'b1, 32'h12345678, 32'h0);
    chk("mtlo preset", 64'(lo), 64'h12345678);
    issue(OP_MUL, 1'b1, 32'hFFFFFFFE, 32'h40000000);
    watch(0, 0, busy_n, done_n, done_at);
    chk("mul busy cycles", 64'(busy_n), 64'd33);
    chk("mul done count", 64'(done_n), 64'd1);
    chk("mul result", 64'(mul_result), 64'h80000000);
    chk("mul hi kept", 64'(hi), 64'h12345678);
    chk("mul lo kept", 64'(lo), 64'h12345678);

    // Reset in MUL cycle 10 discards the op and clears everything.
    issue(OP_MULT, 1'b1, 32'd1000, 32'd1000);
    chk("pre-reset busy", 64'(busy), 64'h1);
    repeat (9) tick();
    rst = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'h0);
    chk("midrst hi", 64'(hi), 64'h0);
    chk("midrst lo", 64'(lo), 64'h0);
    chk("midrst mul_result", 64'(mul_result), 64'h0);
    rst = 1'b1;
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_n++;
      if (busy) busy_n++;
    end
    chk("midrst no done", 64'(done_n), 64'd0);
    chk("midrst no busy", 64'(busy_n), 64'd0);
    chk("midrst hi after", 64'(hi), 64'h0);

    // Signed mult: -3 * 7 = -21.
    issue(OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd7);
    watch(0, 0, busy_n, done_n, done_at);
    chk("mult busy cycles", 64'(busy_n), 64'd33);
    chk("mult done count", 64'(done_n), 64'd1);
    chk("mult done cycle", 64'(done_at), 64'd33);
    chk("mult hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult lo", 64'(lo), 64'hFFFFFFEB);

    // multu with starts poked mid-MUL and in WB, both ignored.
    issue(OP_MULTU, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    watch(10, 33, busy_n, done_n, done_at);
    chk("multu busy cycles", 64'(busy_n), 64'd33);
    chk("multu done cycle", 64'(done_at), 64'd33);
    chk("multu hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu lo", 64'(lo), 64'h00000001);
    tick();
    chk("multu no reaccept", 64'(busy), 64'h0);

    // Accumulate sequence.
    issue(OP_MTHI, 1'b1, 32'd0, 32'd0);
    chk("mthi busy", 64'(busy), 64'h0);
    chk("mthi hi", 64'(hi), 64'h0);
    issue(OP_MTLO, 1'b1, 32'd5, 32'd0);
    chk("mtlo lo", 64'(lo), 64'd5);
    chk("mtlo busy", 64'(busy), 64'h0);
    chk("mtlo done", 64'(done), 64'h0);
    issue(OP_MADD, 1'b1, 32'd2, 32'd3);
    watch(0, 0, busy_n, done_n, done_at);
    chk("madd busy cycles", 64'(busy_n), 64'd33);
    chk("madd hilo", {hi, lo}, 64'h00000000_0000000B);
    issue(OP_MSUB, 1'b1, 32'd4, 32'd3);
    watch(0, 0, busy_n, done_n, done_at);
    chk("msub done count", 64'(done_n), 64'd1);
    chk("msub hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);

    // Ignore cases.
    issue(OP_MTHI, 1'b0, 32'h0000DEAD, 32'h0);
    chk("mthi unqualified", 64'(hi), 64'hFFFFFFFF);
    issue(OP_BAD, 1'b1, 32'h1, 32'h1);
    chk("bad code busy", 64'(busy), 64'h0);
    tick();
    chk("bad code busy later", 64'(busy), 64'h0);
    chk("bad code hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
    issue(OP_MULT, 1'b0, 32'd3, 32'd3);
    chk("mult unqualified busy", 64'(busy), 64'h0);
    tick();
    chk("mult unqualified hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
